// File: rtl/spi_master_burst.sv
// spi_master_burst: mode-3 (CPOL=1, CPHA=1) SPI master for register access.
// Sends an ADDR_W+2 bit header {rw, mb, addr} followed by 1..MAX_BYTES data
// bytes, MSB first, in 4-wire or 3-wire (shared SDIO) mode.
//
// Handshakes: req_i is sampled only in IDLE. Once a transfer is accepted,
// busy_o stays high until the block is back in IDLE. wr_rdy_o pulses for one
// cycle when wr_data_i has been loaded into the shifter. The next write byte
// must then be placed on wr_data_i before the next byte boundary.
// rd_valid_o pulses for one cycle when rd_data_o holds a newly received byte.
// ack_o pulses for one cycle, together with the rise of CS, at the end of the
// transfer.
module spi_master_burst #(
    parameter int ADDR_W    = 6,
    parameter int MAX_BYTES = 8,
    parameter int CLK_DIV   = 2,
    localparam int HDR_W    = ADDR_W + 2,
    localparam int LEN_W    = $clog2(MAX_BYTES + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              rw_ni,
    input  logic              three_wire_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [7:0]        wr_data_i,
    output logic              wr_rdy_o,
    output logic [7:0]        rd_data_o,
    output logic              rd_valid_o,
    output logic              busy_o,
    output logic              ack_o,
    output logic              spi_cs_no,
    output logic              spi_clk_o,
    output logic              spi_data_o,
    input  logic              spi_data_i,
    output logic              spi_oe_o
);

    localparam int CNT_W = $clog2(HDR_W + 8 * MAX_BYTES + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TX_W  = (HDR_W > 8) ? HDR_W : 8;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    // In back-to-back transfers, the IDLE cycle that accepts the next request
    // counts toward the CS-high gap. GAP is therefore one cycle shorter than
    // CLK_DIV, so CS stays high for exactly CLK_DIV cycles.
    localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);
    localparam logic [CNT_W-1:0] HDR_CNT  = CNT_W'(HDR_W);
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  tot_q, tot_d;
    logic [TX_W-1:0]   tx_q, tx_d;
    logic [7:0]        rx_q, rx_d;
    logic              rw_q, rw_d;
    logic              three_q, three_d;
    logic              cs_q, cs_d;
    logic              sclk_q, sclk_d;
    logic              oe_q, oe_d;
    logic              busy_q, busy_d;
    logic              ack_q, ack_d;
    logic              wr_rdy_q, wr_rdy_d;
    logic              rd_valid_q, rd_valid_d;
    logic [7:0]        rd_data_q, rd_data_d;

    logic [LEN_W-1:0]  len_n;
    logic [HDR_W-1:0]  hdr;
    logic [CNT_W-1:0]  tot_calc;
    logic [CNT_W-1:0]  nb;
    logic              div_last;
    logic              in_data;
    logic              byte_start;
    logic              byte_end;

    // Normalise the length, build the header, and decode bit-position flags.
    always_comb begin
        len_n = len_i;
        if (len_i == '0) begin
            len_n = LEN_W'(1);
        end else if (len_i > MAX_LEN) begin
            len_n = MAX_LEN;
        end
        hdr        = {rw_ni, (len_n > LEN_W'(1)), addr_i};
        tot_calc   = HDR_CNT + (CNT_W'(len_n) << 3);
        nb         = bit_cnt_q - HDR_CNT;
        div_last   = (div_q == DIV_LAST);
        in_data    = (bit_cnt_q >= HDR_CNT);
        byte_start = in_data && (nb[2:0] == 3'd0);
        byte_end   = in_data && (nb[2:0] == 3'd7);
    end

    // Next-state logic for the transfer FSM, the SCLK divider and the shifters.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_cnt_d  = bit_cnt_q;
        tot_d      = tot_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rw_d       = rw_q;
        three_d    = three_q;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        ack_d      = 1'b0;
        wr_rdy_d   = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    rw_d      = rw_ni;
                    three_d   = three_wire_i;
                    tot_d     = tot_calc;
                    tx_d      = TX_W'(hdr) << (TX_W - HDR_W);
                    bit_cnt_d = '0;
                    div_d     = '0;
                    cs_d      = 1'b0;
                    sclk_d    = 1'b1;
                    oe_d      = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = ST_SETUP;
                end
            end

            ST_SETUP: begin
                div_d = div_q + 1'b1;
                if (div_last) begin
                    // The first falling edge keeps the header MSB already on the line.
                    div_d   = '0;
                    sclk_d  = 1'b0;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                div_d = div_q + 1'b1;
                if (div_last) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        // Rising edge: sample the input line.
                        sclk_d    = 1'b1;
                        rx_d      = {rx_q[6:0], spi_data_i};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (rw_q && byte_end) begin
                            rd_data_d  = {rx_q[6:0], spi_data_i};
                            rd_valid_d = 1'b1;
                        end
                    end else if (bit_cnt_q == tot_q) begin
                        state_d = ST_HOLD;
                    end else begin
                        // Falling edge: present the next bit.
                        sclk_d = 1'b0;
                        if (byte_start && !rw_q) begin
                            tx_d     = TX_W'(wr_data_i) << (TX_W - 8);
                            wr_rdy_d = 1'b1;
                        end else begin
                            tx_d = tx_q << 1;
                        end
                        // 3-wire read: release SDIO once the header has been sent.
                        if (bit_cnt_q == HDR_CNT && three_q && rw_q) begin
                            oe_d = 1'b0;
                        end
                    end
                end
            end

            ST_HOLD: begin
                div_d = div_q + 1'b1;
                if (div_last) begin
                    div_d = '0;
                    cs_d  = 1'b1;
                    ack_d = 1'b1;
                    oe_d  = 1'b0;
                    tx_d  = '0;
                    if (CLK_DIV > 1) begin
                        state_d = ST_GAP;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_GAP: begin
                div_d = div_q + 1'b1;
                if (div_q == GAP_LAST) begin
                    div_d   = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset overrides any transfer in progress.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            bit_cnt_q  <= '0;
            tot_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            rw_q       <= 1'b0;
            three_q    <= 1'b0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b1;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            wr_rdy_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            tot_q      <= tot_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rw_q       <= rw_d;
            three_q    <= three_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            wr_rdy_q   <= wr_rdy_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign wr_rdy_o   = wr_rdy_q;
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign busy_o     = busy_q;
    assign ack_o      = ack_q;
    assign spi_cs_no  = cs_q;
    assign spi_clk_o  = sclk_q;
    assign spi_data_o = tx_q[TX_W-1];
    assign spi_oe_o   = oe_q;

endmodule

// File: tb/tb_spi_master_burst.sv
// tb_spi_master_burst: bench for spi_master_burst with a mode-3 slave model and
// scoreboards for MOSI bytes and read bytes.
module tb_spi_master_burst;

    localparam int ADDR_W    = 6;
    localparam int MAX_BYTES = 8;
    localparam int CLK_DIV   = 2;
    localparam int HDR_W     = ADDR_W + 2;
    localparam int LEN_W     = 4;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              req_i = 1'b0;
    logic              rw_ni = 1'b0;
    logic              three_wire_i = 1'b0;
    logic [ADDR_W-1:0] addr_i = '0;
    logic [LEN_W-1:0]  len_i = '0;
    logic [7:0]        wr_data_i = '0;
    logic              wr_rdy_o;
    logic [7:0]        rd_data_o;
    logic              rd_valid_o;
    logic              busy_o;
    logic              ack_o;
    logic              spi_cs_no;
    logic              spi_clk_o;
    logic              spi_data_o;
    logic              spi_data_i = 1'b0;
    logic              spi_oe_o;

    spi_master_burst #(
        .ADDR_W    (ADDR_W),
        .MAX_BYTES (MAX_BYTES),
        .CLK_DIV   (CLK_DIV)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .rw_ni        (rw_ni),
        .three_wire_i (three_wire_i),
        .addr_i       (addr_i),
        .len_i        (len_i),
        .wr_data_i    (wr_data_i),
        .wr_rdy_o     (wr_rdy_o),
        .rd_data_o    (rd_data_o),
        .rd_valid_o   (rd_valid_o),
        .busy_o       (busy_o),
        .ack_o        (ack_o),
        .spi_cs_no    (spi_cs_no),
        .spi_clk_o    (spi_clk_o),
        .spi_data_o   (spi_data_o),
        .spi_data_i   (spi_data_i),
        .spi_oe_o     (spi_oe_o)
    );

    // Clock generation.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_rd_q[$];
    logic [7:0] exp_mosi_q[$];
    logic       miso_q[$];
    logic [7:0] tx_bytes[8];
    logic [7:0] rx_bytes[8];

    int   cyc = 0;
    int   cs_fall_cyc = 0;
    int   cs_rise_cyc = 0;
    int   cs_low_len = 0;
    int   ack_cnt = 0;
    int   ack_cyc = 0;
    int   wr_cnt = 0;
    int   wr_cnt_txn = 0;
    int   last_wr_cyc = 0;
    int   rd_cnt = 0;
    int   mbit = 0;
    int   wr_idx = 0;
    logic cs_prev = 1'b1;
    logic mon_en = 1'b0;
    logic cur_rw = 1'b0;
    logic cur_three = 1'b0;
    logic [7:0] mosi_sr = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave model: present the next bit on each SCLK falling edge.
    always @(negedge spi_clk_o) begin
        if (mon_en && !spi_cs_no && miso_q.size() > 0) spi_data_i = miso_q.pop_front();
    end

    always @(negedge spi_cs_no) mbit = 0;

    // Slave model: capture MOSI and check SDIO direction on each SCLK rising edge.
    always @(posedge spi_clk_o) begin
        if (mon_en && !spi_cs_no) begin
            check_eq("oe_bit", {31'd0, spi_oe_o}, (cur_three && cur_rw && mbit >= HDR_W) ? 32'd0 : 32'd1);
            mosi_sr = {mosi_sr[6:0], spi_data_o};
            mbit++;
            if (mbit % 8 == 0 && (mbit == HDR_W || !cur_rw)) begin
                if (exp_mosi_q.size() == 0) check_eq("mosi_extra", 1, 0);
                else check_eq("mosi_byte", {24'd0, mosi_sr}, {24'd0, exp_mosi_q.pop_front()});
            end
        end
    end

    // One clock step; sample the DUT on the falling edge of clk.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (cs_prev && !spi_cs_no) cs_fall_cyc = cyc;
        if (!cs_prev && spi_cs_no) begin
            cs_rise_cyc = cyc;
            cs_low_len  = cyc - cs_fall_cyc;
        end
        if (ack_o) begin
            ack_cnt++;
            ack_cyc = cyc;
        end
        if (wr_rdy_o) begin
            if (wr_cnt_txn > 0) check_eq("wr_rdy_gap", cyc - last_wr_cyc, 16 * CLK_DIV);
            wr_cnt++;
            wr_cnt_txn++;
            last_wr_cyc = cyc;
            wr_idx++;
            if (wr_idx < 8) wr_data_i = tx_bytes[wr_idx];
        end
        if (rd_valid_o) begin
            rd_cnt++;
            if (exp_rd_q.size() == 0) check_eq("rd_extra", 1, 0);
            else check_eq("rd_data", {24'd0, rd_data_o}, {24'd0, exp_rd_q.pop_front()});
        end
        cs_prev = spi_cs_no;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 8; i++) begin
            tx_bytes[i] = 8'($urandom_range(0, 255));
            rx_bytes[i] = 8'($urandom_range(0, 255));
        end
    endtask

    // Drive one transaction, push its expectations and run until ack_o.
    task automatic run_txn(input logic rw, input logic three, input logic [ADDR_W-1:0] addr,
                           input logic [LEN_W-1:0] len, input bit hold, input bit pulse_mid);
        int n;
        int ack0;
        int wr0;
        int rd0;
        int t;
        bit started;
        logic [7:0] hdr;
        n = (len == 0) ? 1 : ((len > MAX_BYTES) ? MAX_BYTES : int'(len));
        hdr = {rw, (n > 1), addr};
        exp_mosi_q.push_back(hdr);
        for (int i = 0; i < n; i++) begin
            if (rw) exp_rd_q.push_back(rx_bytes[i]);
            else exp_mosi_q.push_back(tx_bytes[i]);
        end
        for (int b = 0; b < HDR_W; b++) miso_q.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < n; i++)
            for (int b = 7; b >= 0; b--) miso_q.push_back(rx_bytes[i][b]);
        cur_rw = rw;
        cur_three = three;
        wr_idx = 0;
        wr_cnt_txn = 0;
        mon_en = 1'b1;
        ack0 = ack_cnt;
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        req_i = 1'b1;
        rw_ni = rw;
        three_wire_i = three;
        addr_i = addr;
        len_i = len;
        wr_data_i = tx_bytes[0];
        started = 1'b0;
        t = 0;
        while (ack_cnt == ack0 && t < 3000) begin
            tick();
            t++;
            if (!spi_cs_no && !started) begin
                started = 1'b1;
                check_eq("busy_on", {31'd0, busy_o}, 1);
                if (!hold) req_i = 1'b0;
            end
            if (pulse_mid && t == 40) begin
                req_i = 1'b1;
                addr_i = ~addr;
            end
            if (pulse_mid && t == 41) req_i = 1'b0;
        end
        check_eq("ack_seen", ack_cnt - ack0, 1);
        check_eq("cs_low_len", cs_low_len, CLK_DIV * (2 + 2 * (HDR_W + 8 * n)));
        check_eq("ack_at_cs_rise", ack_cyc, cs_rise_cyc);
        check_eq("wr_rdy_cnt", wr_cnt - wr0, rw ? 0 : n);
        check_eq("rd_cnt", rd_cnt - rd0, rw ? n : 0);
        check_eq("sclk_rises", mbit, HDR_W + 8 * n);
        check_eq("rd_q_left", exp_rd_q.size(), 0);
        check_eq("mosi_q_left", exp_mosi_q.size(), 0);
        check_eq("oe_after", {31'd0, spi_oe_o}, 0);
        if (!hold) begin
            tick();
            check_eq("busy_off", {31'd0, busy_o}, 0);
        end
    endtask

    // Main stimulus sequence.
    initial begin
        int rise1;
        int fall0;
        int ack0;
        int rd0;
        int t;

        // Reset state.
        for (int i = 0; i < 3; i++) tick();
        check_eq("rst_cs", {31'd0, spi_cs_no}, 1);
        check_eq("rst_sclk", {31'd0, spi_clk_o}, 1);
        check_eq("rst_mosi", {31'd0, spi_data_o}, 0);
        check_eq("rst_oe", {31'd0, spi_oe_o}, 0);
        check_eq("rst_busy", {31'd0, busy_o}, 0);
        check_eq("rst_ack", {31'd0, ack_o}, 0);
        check_eq("rst_wr_rdy", {31'd0, wr_rdy_o}, 0);
        check_eq("rst_rd_valid", {31'd0, rd_valid_o}, 0);
        check_eq("rst_rd_data", {24'd0, rd_data_o}, 0);
        rst_i = 1'b0;
        tick();

        // Single 4-wire read of addr 0x00 returning 0xE5.
        fill_random();
        rx_bytes[0] = 8'hE5;
        run_txn(1'b1, 1'b0, 6'h00, 4'd1, 1'b0, 1'b0);

        // Single write 0x08 to addr 0x2D; a mid-transfer request pulse is ignored.
        tx_bytes[0] = 8'h08;
        fall0 = cs_fall_cyc;
        run_txn(1'b0, 1'b0, 6'h2D, 4'd1, 1'b0, 1'b1);
        for (int i = 0; i < 4 * CLK_DIV; i++) tick();
        check_eq("mid_req_ignored_cs", {31'd0, spi_cs_no}, 1);
        check_eq("mid_req_ignored_busy", {31'd0, busy_o}, 0);

        // 3-wire burst read of addr 0x32 returning 0x01..0x06.
        for (int i = 0; i < 6; i++) rx_bytes[i] = 8'(i + 1);
        run_txn(1'b1, 1'b1, 6'h32, 4'd6, 1'b0, 1'b0);

        // Length edges and bursts with random data.
        fill_random();
        run_txn(1'b0, 1'b0, 6'(($urandom_range(0, 63))), 4'd0, 1'b0, 1'b0);
        fill_random();
        run_txn(1'b1, 1'b0, 6'(($urandom_range(0, 63))), 4'd15, 1'b0, 1'b0);
        fill_random();
        run_txn(1'b0, 1'b0, 6'h1E, 4'd4, 1'b0, 1'b0);
        fill_random();
        run_txn(1'b0, 1'b1, 6'h31, 4'd2, 1'b0, 1'b0);

        // Back-to-back with req_i held high.
        fill_random();
        run_txn(1'b1, 1'b0, 6'h05, 4'd2, 1'b1, 1'b0);
        rise1 = cs_rise_cyc;
        fill_random();
        run_txn(1'b0, 1'b0, 6'h06, 4'd1, 1'b0, 1'b0);
        check_eq("b2b_gap", cs_fall_cyc - rise1, CLK_DIV);

        // Reset during byte 2 of a 4-byte read.
        fill_random();
        exp_mosi_q.push_back({1'b1, 1'b1, 6'h15});
        exp_rd_q.push_back(rx_bytes[0]);
        for (int b = 0; b < HDR_W; b++) miso_q.push_back(1'b0);
        for (int i = 0; i < 4; i++)
            for (int b = 7; b >= 0; b--) miso_q.push_back(rx_bytes[i][b]);
        cur_rw = 1'b1;
        cur_three = 1'b0;
        mon_en = 1'b1;
        rd0 = rd_cnt;
        ack0 = ack_cnt;
        req_i = 1'b1;
        rw_ni = 1'b1;
        three_wire_i = 1'b0;
        addr_i = 6'h15;
        len_i = 4'd4;
        tick();
        req_i = 1'b0;
        t = 0;
        while (rd_cnt == rd0 && t < 500) begin
            tick();
            t++;
        end
        check_eq("rst_mid_first_byte", rd_cnt - rd0, 1);
        for (int i = 0; i < 20; i++) tick();
        mon_en = 1'b0;
        rst_i = 1'b1;
        tick();
        check_eq("midrst_cs", {31'd0, spi_cs_no}, 1);
        check_eq("midrst_sclk", {31'd0, spi_clk_o}, 1);
        check_eq("midrst_oe", {31'd0, spi_oe_o}, 0);
        check_eq("midrst_busy", {31'd0, busy_o}, 0);
        check_eq("midrst_ack", {31'd0, ack_o}, 0);
        check_eq("midrst_rd_valid", {31'd0, rd_valid_o}, 0);
        rst_i = 1'b0;
        miso_q.delete();
        exp_mosi_q.delete();
        for (int i = 0; i < 10; i++) tick();
        check_eq("midrst_no_ack", ack_cnt - ack0, 0);
        check_eq("midrst_no_rd", rd_cnt - rd0, 1);
        fill_random();
        run_txn(1'b1, 1'b0, 6'h15, 4'd3, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
